pulse_scheduler: RTL and testbench

PULSE_SCHEDULER -- requirements
Module: pulse_scheduler

---
 rtl/pulse_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_pulse_scheduler.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_scheduler.sv
// pulse_scheduler: fetches timing descriptors from a show-ahead FIFO and plays
// each one out as a delayed, fixed-width pulse on one of N_CH channels.
// Descriptor layout: [31:16] delay, [15:4] width, [3:0] channel.
// Optional feature: define PULSE_SCHED_CHK_EN to discard descriptors whose
// channel is out of range and raise a sticky err flag instead.
`timescale 1ns/1ps

module pulse_scheduler #(
    parameter int DW   = 32,
    parameter int N_CH = 8
) (
    input  logic            clk_rd,
    input  logic            rst_rd,
    input  logic            enable,
    input  logic            abort,
    input  logic            fifo_empty,
    input  logic [DW-1:0]   fifo_rd_data,
    output logic            fifo_rd_en,
    output logic [N_CH-1:0] pulse_out,
    output logic            busy,
    output logic            pulse_done,
    input  logic            err_clr,
    output logic            err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PULSE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [15:0]     dcnt_q, dcnt_d;
    logic [11:0]     wcnt_q, wcnt_d;
    logic [3:0]      chan_q, chan_d;
    logic [N_CH-1:0] pulse_q, pulse_d;
    logic            done_q, done_d;
    logic            err_q, err_d;

    logic            pop;
    logic            rd_bad;
    logic [15:0]     rd_delay;
    logic [11:0]     rd_width;
    logic [3:0]      rd_chan;
    logic [N_CH-1:0] rd_mask;
    logic [N_CH-1:0] q_mask;

    // One-hot channel decode; channels outside 0..N_CH-1 decode to all-zero
    function automatic logic [N_CH-1:0] chan_mask(input logic [3:0] ch);
        logic [N_CH-1:0] m;
        m = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (ch == 4'(i)) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

    generate
        if (DW > 32) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^fifo_rd_data[DW-1:32];
        end
    endgenerate

    assign rd_delay = fifo_rd_data[31:16];
    assign rd_width = fifo_rd_data[15:4];
    assign rd_chan  = fifo_rd_data[3:0];
    assign rd_mask  = chan_mask(rd_chan);
    assign q_mask   = chan_mask(chan_q);

    // The pop strobe is combinational so the head word is consumed in the same
    // cycle it is latched; reset and abort both suppress it
    assign pop = ~rst_rd & (state_q == IDLE) & enable & ~fifo_empty & ~abort;

`ifdef PULSE_SCHED_CHK_EN
    assign rd_bad = ({28'd0, rd_chan} >= N_CH);
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign rd_bad         = 1'b0;
`endif

    // Next-state logic: fetch, count down the delay, then hold the pulse
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        wcnt_d  = wcnt_q;
        chan_d  = chan_q;
        pulse_d = pulse_q;
        done_d  = 1'b0;
`ifdef PULSE_SCHED_CHK_EN
        err_d   = (err_q & ~err_clr) | (pop & rd_bad);
`else
        err_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pop) begin
                    chan_d = rd_chan;
                    wcnt_d = rd_width;
                    dcnt_d = rd_delay;
                    if (rd_bad) begin
                        state_d = IDLE;
                    end else if (rd_delay != 16'd0) begin
                        state_d = DELAY;
                    end else if (rd_width != 12'd0) begin
                        state_d = PULSE;
                        pulse_d = rd_mask;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            DELAY: begin
                if (abort) begin
                    state_d = IDLE;
                    dcnt_d  = 16'd0;
                    pulse_d = '0;
                end else if (dcnt_q <= 16'd1) begin
                    dcnt_d = 16'd0;
                    if (wcnt_q != 12'd0) begin
                        state_d = PULSE;
                        pulse_d = q_mask;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    dcnt_d = dcnt_q - 16'd1;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_d = IDLE;
                    wcnt_d  = 12'd0;
                    pulse_d = '0;
                end else if (wcnt_q <= 12'd1) begin
                    state_d = IDLE;
                    wcnt_d  = 12'd0;
                    pulse_d = '0;
                    done_d  = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 12'd1;
                end
            end
            default: begin
                state_d = IDLE;
                pulse_d = '0;
            end
        endcase
    end

    // State and output registers; reset clears everything immediately
    always_ff @(posedge clk_rd or posedge rst_rd) begin
        if (rst_rd) begin
            state_q <= IDLE;
            dcnt_q  <= 16'd0;
            wcnt_q  <= 12'd0;
            chan_q  <= 4'd0;
            pulse_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            wcnt_q  <= wcnt_d;
            chan_q  <= chan_d;
            pulse_q <= pulse_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign fifo_rd_en = pop;
    assign pulse_out  = pulse_q;
    assign pulse_done = done_q;
    assign busy       = (state_q != IDLE);
    assign err        = err_q;

endmodule

// File: tb/tb_pulse_scheduler.sv
// Testbench for pulse_scheduler. Expected behaviour comes from a timeline
// model: a descriptor popped at cycle T is busy over T+1..T+d+w, pulses over
// T+1+d..T+d+w and strobes done at T+1+d+w. Honours PULSE_SCHED_CHK_EN.
`timescale 1ns/1ps

module tb_pulse_scheduler;

    localparam int N_CH = 8;

    logic            clk_rd = 1'b0;
    logic            rst_rd;
    logic            enable;
    logic            abort;
    logic            fifo_empty;
    logic [31:0]     fifo_rd_data;
    logic            fifo_rd_en;
    logic [N_CH-1:0] pulse_out;
    logic            busy;
    logic            pulse_done;
    logic            err_clr;
    logic            err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] fq[$];
    int pop_log[$];
    int done_log[$];
    int pulse_log[$];

    bit m_active = 1'b0;
    bit m_err    = 1'b0;
    int m_T = 0, m_d = 0, m_w = 0, m_ch = 0;

    pulse_scheduler #(.DW(32), .N_CH(N_CH)) dut (
        .clk_rd       (clk_rd),
        .rst_rd       (rst_rd),
        .enable       (enable),
        .abort        (abort),
        .fifo_empty   (fifo_empty),
        .fifo_rd_data (fifo_rd_data),
        .fifo_rd_en   (fifo_rd_en),
        .pulse_out    (pulse_out),
        .busy         (busy),
        .pulse_done   (pulse_done),
        .err_clr      (err_clr),
        .err          (err)
    );

    always #5 clk_rd = ~clk_rd;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
        end
    endtask

    task automatic sync_fifo();
        fifo_empty   = (fq.size() == 0);
        fifo_rd_data = (fq.size() != 0) ? fq[0] : 32'h0;
    endtask

    task automatic clear_logs();
        pop_log.delete();
        done_log.delete();
        pulse_log.delete();
    endtask

    // One clock cycle: check outputs at the falling edge against the timeline
    // model, then advance the model and the FIFO on the rising edge
    task automatic apply_stimulus();
        int c = cyc;
        logic [N_CH-1:0] ep;
        logic eb, ed, epop, idle, bad, seen_pop;
        logic [31:0] desc;
        @(negedge clk_rd);
        idle = !m_active || (c >= m_T + 1 + m_d + m_w);
        eb   = m_active && (c >= m_T + 1) && (c <= m_T + m_d + m_w);
        ed   = m_active && (c == m_T + 1 + m_d + m_w);
        ep   = '0;
        if (m_active && (c >= m_T + 1 + m_d) && (c <= m_T + m_d + m_w) && (m_ch < N_CH))
            ep[m_ch] = 1'b1;
        epop = idle && enable && (fq.size() != 0) && !abort;
        check_output("fifo_rd_en", {31'd0, fifo_rd_en}, {31'd0, epop});
        check_output("busy", {31'd0, busy}, {31'd0, eb});
        check_output("pulse_out", {24'd0, pulse_out}, {24'd0, ep});
        check_output("pulse_done", {31'd0, pulse_done}, {31'd0, ed});
        check_output("err", {31'd0, err}, {31'd0, m_err});
        seen_pop = fifo_rd_en;
        if (fifo_rd_en) pop_log.push_back(c);
        if (pulse_done) done_log.push_back(c);
        if (pulse_out != '0) pulse_log.push_back(c);
        bad = 1'b0;
        if (abort && eb) m_active = 1'b0;
        if (epop) begin
            desc = fq[0];
`ifdef PULSE_SCHED_CHK_EN
            bad = ({28'd0, desc[3:0]} >= N_CH);
`endif
            if (bad) begin
                m_active = 1'b0;
            end else begin
                m_active = 1'b1;
                m_T  = c;
                m_d  = int'(desc[31:16]);
                m_w  = int'(desc[15:4]);
                m_ch = int'(desc[3:0]);
            end
        end
`ifdef PULSE_SCHED_CHK_EN
        m_err = (m_err && !err_clr) || (epop && bad);
`else
        m_err = 1'b0;
`endif
        @(posedge clk_rd);
        #1;
        if (seen_pop && fq.size() != 0) void'(fq.pop_front());
        cyc++;
        sync_fifo();
    endtask

    // Assert reset partway through the current cycle and expect every output low at once
    task automatic reset_mid(input string tag);
        #2;
        rst_rd = 1'b1;
        #1;
        check_output({tag, "_pulse_out"}, {24'd0, pulse_out}, 32'd0);
        check_output({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check_output({tag, "_pulse_done"}, {31'd0, pulse_done}, 32'd0);
        check_output({tag, "_fifo_rd_en"}, {31'd0, fifo_rd_en}, 32'd0);
        check_output({tag, "_err"}, {31'd0, err}, 32'd0);
        m_active = 1'b0;
        m_err    = 1'b0;
        @(posedge clk_rd);
        #1;
        rst_rd = 1'b0;
        cyc++;
        sync_fifo();
    endtask

    initial begin
        rst_rd  = 1'b1;
        enable  = 1'b1;
        abort   = 1'b0;
        err_clr = 1'b0;
        fq.push_back(32'h0000_0011);
        sync_fifo();
        repeat (3) @(posedge clk_rd);
        #1;
        $display("[TB] reset state");
        check_output("rst_fifo_rd_en", {31'd0, fifo_rd_en}, 32'd0);
        check_output("rst_pulse_out", {24'd0, pulse_out}, 32'd0);
        check_output("rst_busy", {31'd0, busy}, 32'd0);
        check_output("rst_pulse_done", {31'd0, pulse_done}, 32'd0);
        check_output("rst_err", {31'd0, err}, 32'd0);
        fq.delete();
        sync_fifo();
        rst_rd = 1'b0;
        cyc    = 0;

        $display("[TB] single descriptor popped at cycle 10");
        clear_logs();
        while (cyc < 10) apply_stimulus();
        fq.push_back(32'h0003_0052);
        sync_fifo();
        repeat (11) apply_stimulus();
        check_output("s1_pop_cycle", (pop_log.size() > 0) ? pop_log[0] : -1, 32'd10);
        check_output("s1_first_pulse", (pulse_log.size() > 0) ? pulse_log[0] : -1, 32'd14);
        check_output("s1_pulse_len", pulse_log.size(), 32'd5);
        check_output("s1_done_cycle", (done_log.size() > 0) ? done_log[0] : -1, 32'd19);

        $display("[TB] back-to-back width-1 pulses");
        clear_logs();
        fq.push_back(32'h0000_0010);
        fq.push_back(32'h0000_0011);
        sync_fifo();
        repeat (8) apply_stimulus();
        check_output("s2_done_count", done_log.size(), 32'd2);
        check_output("s2_pulse_count", pulse_log.size(), 32'd2);
        check_output("s2_pulse_gap", (pulse_log.size() == 2) ? pulse_log[1] - pulse_log[0] : -1, 32'd2);

        $display("[TB] abort on second cycle of width-10 pulse");
        clear_logs();
        fq.push_back(32'h0000_00A3);
        fq.push_back(32'h0000_0015);
        sync_fifo();
        apply_stimulus();
        apply_stimulus();
        abort = 1'b1;
        apply_stimulus();
        abort = 1'b0;
        check_output("s3_pulse_cleared", {24'd0, pulse_out}, 32'd0);
        check_output("s3_busy_cleared", {31'd0, busy}, 32'd0);
        repeat (6) apply_stimulus();
        check_output("s3_pop_count", pop_log.size(), 32'd2);
        check_output("s3_next_pop", (pop_log.size() == 2) ? pop_log[1] - pop_log[0] : -1, 32'd3);
        check_output("s3_done_count", done_log.size(), 32'd1);

        $display("[TB] enable low with three words queued");
        clear_logs();
        enable = 1'b0;
        fq.push_back(32'h0001_0023);
        fq.push_back(32'h0000_0017);
        fq.push_back(32'h0002_0010);
        sync_fifo();
        repeat (5) apply_stimulus();
        check_output("s4_no_pop", pop_log.size(), 32'd0);
        enable = 1'b1;
        repeat (14) apply_stimulus();
        check_output("s4_pop_count", pop_log.size(), 32'd3);
        check_output("s4_done_count", done_log.size(), 32'd3);

        $display("[TB] zero-width descriptors");
        clear_logs();
        fq.push_back(32'h0002_0005);
        fq.push_back(32'h0000_0006);
        sync_fifo();
        repeat (8) apply_stimulus();
        check_output("s5_done_count", done_log.size(), 32'd2);
        check_output("s5_no_pulse", pulse_log.size(), 32'd0);

        $display("[TB] out-of-range channel");
        clear_logs();
        fq.push_back(32'h0001_001A);
        sync_fifo();
        repeat (5) apply_stimulus();
        check_output("s6_pop_count", pop_log.size(), 32'd1);
        check_output("s6_no_pulse", pulse_log.size(), 32'd0);
`ifdef PULSE_SCHED_CHK_EN
        check_output("s6_err_set", {31'd0, err}, 32'd1);
        check_output("s6_no_done", done_log.size(), 32'd0);
        err_clr = 1'b1;
        apply_stimulus();
        err_clr = 1'b0;
        check_output("s6_err_cleared", {31'd0, err}, 32'd0);
        fq.push_back(32'h0001_001A);
        sync_fifo();
        apply_stimulus();
        err_clr = 1'b1;
        fq.push_back(32'h0001_001B);
        sync_fifo();
        apply_stimulus();
        err_clr = 1'b0;
        check_output("s6_err_coincide", {31'd0, err}, 32'd1);
        err_clr = 1'b1;
        apply_stimulus();
        err_clr = 1'b0;
`else
        check_output("s6_done_count", done_log.size(), 32'd1);
        check_output("s6_done_cycle", (done_log.size() > 0 && pop_log.size() > 0) ? done_log[0] - pop_log[0] : -1, 32'd3);
        err_clr = 1'b1;
        apply_stimulus();
        err_clr = 1'b0;
        check_output("s6_err_tied", {31'd0, err}, 32'd0);
`endif
        repeat (2) apply_stimulus();

        $display("[TB] reset during DELAY and during PULSE");
        clear_logs();
        fq.push_back(32'h0005_0041);
        sync_fifo();
        repeat (3) apply_stimulus();
        check_output("s7_busy_delay", {31'd0, busy}, 32'd1);
        reset_mid("s7_delay");
        repeat (2) apply_stimulus();
        fq.push_back(32'h0001_0041);
        sync_fifo();
        repeat (3) apply_stimulus();
        check_output("s7_pulse_before", {24'd0, pulse_out}, 32'h2);
        reset_mid("s7_pulse");
        clear_logs();
        fq.push_back(32'h0000_0012);
        sync_fifo();
        repeat (4) apply_stimulus();
        check_output("s7_pop_after_reset", (pop_log.size() > 0) ? pop_log[0] : -1, cyc - 4);
        check_output("s7_done_after_reset", done_log.size(), 32'd1);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 3 && ($urandom % 3) == 0) begin
                fq.push_back({16'($urandom_range(0, 3)), 12'($urandom_range(0, 4)),
                              4'($urandom_range(0, N_CH + 1))});
            end
            enable  = (($urandom % 5) != 0);
            abort   = (($urandom % 20) == 0);
            err_clr = (($urandom % 8) == 0);
            sync_fifo();
            apply_stimulus();
        end
        enable  = 1'b1;
        abort   = 1'b0;
        err_clr = 1'b0;
        repeat (30) apply_stimulus();
        check_output("rand_drained", fq.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
